// File: rtl/fir_decim_round_out_if.sv
// Bus bundle between the FIR output stage and its neighbours.
// The slave side is the output stage: it consumes filter samples and control strobes
// and presents the FIFO head with valid/ready toward the consumer.
interface fir_decim_round_out_if #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
);
    // Filter side: no backpressure toward the filter.
    logic                               valid_in;
    logic signed [INPUT_WIDTH-1:0]      din;
    logic                               phase_rst;
    // Consumer side.
    logic                               valid_out;
    logic                               ready_in;
    logic signed [OUTPUT_WIDTH-1:0]     dout;
    logic                               sat_out;
    logic [$clog2(FIFO_DEPTH):0]        fifo_level;
    // Status.
    logic                               overflow;
    logic                               clear_ovf;

    modport master (
        output valid_in, din, phase_rst, ready_in, clear_ovf,
        input  valid_out, dout, sat_out, fifo_level, overflow
    );

    modport slave (
        input  valid_in, din, phase_rst, ready_in, clear_ovf,
        output valid_out, dout, sat_out, fifo_level, overflow
    );
endinterface

// File: rtl/fir_decim_round_out.sv
// Decimate, round/shift, saturate and queue FIR results in a small FWFT FIFO.
// Latency: valid_in in cycle N -> valid_out in cycle N+3 when the FIFO is empty.
// Backpressure: none toward the filter; a kept sample hitting a full FIFO is dropped
// and sets the sticky overflow flag (cleared by clear_ovf when no drop occurs).
// Ports: clk, rst (sync, active-high); io (slave modport) carries valid_in/din/phase_rst
// from the filter, valid_out/ready_in/dout/sat_out/fifo_level toward the consumer,
// and overflow/clear_ovf status.
module fir_decim_round_out #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT        = 10,
    parameter int ROUND        = 1,
    parameter int DECIM        = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst,
    fir_decim_round_out_if.slave io
);
    localparam int IW = INPUT_WIDTH;
    localparam int OW = OUTPUT_WIDTH;
    localparam int SW = INPUT_WIDTH + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1 % DECIM);
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

    // Half-LSB of the post-shift result; zero when truncating or not shifting.
    localparam logic signed [SW-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    // Output range limits expressed at the internal width.
    localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // ---------------- decimation phase ----------------
    logic [CW-1:0] cnt;
    logic          keep;

    // phase_rst forces the current beat to be kept so the new phase starts here.
    assign keep = io.valid_in && (io.phase_rst || cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (io.valid_in) begin
            if (io.phase_rst)        cnt <= CNT_ONE;
            else if (cnt == CNT_LAST) cnt <= '0;
            else                      cnt <= cnt + CW'(1);
        end else if (io.phase_rst) begin
            cnt <= '0;
        end
    end

    // ---------------- S1: sign-extend and add rounding constant ----------------
    logic                 s1_vld;
    logic signed [SW-1:0] s1_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_sum <= '0;
        end else begin
            s1_vld <= keep;
            if (keep) s1_sum <= $signed({io.din[IW-1], io.din}) + RND;
        end
    end

    // ---------------- S2: shift and saturate ----------------
    logic signed [SW-1:0] q;
    logic                 q_hi;
    logic                 q_lo;
    logic                 s2_vld;
    logic                 s2_sat;
    logic [OW-1:0]        s2_dat;

    assign q    = s1_sum >>> SHIFT;
    assign q_hi = q > MAXV;
    assign q_lo = q < MINV;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_sat <= 1'b0;
            s2_dat <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sat <= q_hi || q_lo;
                s2_dat <= q_hi ? MAXV[OW-1:0] : (q_lo ? MINV[OW-1:0] : q[OW-1:0]);
            end
        end
    end

    // ---------------- output FIFO (first-word fall-through) ----------------
    logic [OW:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;
    logic          pop;
    logic          wr;
    logic          drop;

    assign pop  = (level != '0) && io.ready_in;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr   = s2_vld && ((level != LW'(FIFO_DEPTH)) || pop);
    assign drop = s2_vld && !wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            // Storage is cleared so dout/sat_out read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= {s2_sat, s2_dat};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A drop in the same cycle wins over the clear request.
            if (drop)              ovf <= 1'b1;
            else if (io.clear_ovf) ovf <= 1'b0;
        end
    end

    assign io.valid_out  = (level != '0);
    assign io.dout       = mem[rd_ptr][OW-1:0];
    assign io.sat_out    = mem[rd_ptr][OW];
    assign io.fifo_level = level;
    assign io.overflow   = ovf;
endmodule
